// File: rtl/despacho_pkg.sv
// Shared constants for the dispatch unit: opcodes, functional-unit codes, FSM encoding, tag width.
package despacho_pkg;

    localparam int unsigned TAG_W    = 4;
    localparam int unsigned REG_W    = 4;
    localparam int unsigned NUM_REGS = 16;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LD  = 4'h1;
    localparam logic [3:0] OP_ST  = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_MUL = 4'h5;

    localparam logic [1:0] UNIT_ALU = 2'b00;
    localparam logic [1:0] UNIT_MUL = 2'b01;
    localparam logic [1:0] UNIT_MEM = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_POP   = 2'b01,
        S_ISSUE = 2'b10
    } estado_t;

    function automatic logic op_valido(input logic [3:0] op);
        return (op >= OP_LD) && (op <= OP_MUL);
    endfunction

    // ST consumes a reservation station but produces no register result.
    function automatic logic escreve_rd(input logic [3:0] op);
        return op_valido(op) && (op != OP_ST);
    endfunction

    function automatic logic [1:0] unidade_de(input logic [3:0] op);
        logic [1:0] u;
        case (op)
            OP_ADD, OP_SUB: u = UNIT_ALU;
            OP_MUL:         u = UNIT_MUL;
            OP_LD, OP_ST:   u = UNIT_MEM;
            default:        u = UNIT_ALU;
        endcase
        return u;
    endfunction

endpackage

// File: rtl/tabela_status_registradores.sv
// Register status table (Qi per architectural register) with CDB clear and bypassed read ports.
module tabela_status_registradores
    import despacho_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [REG_W-1:0] i_rs1,
    input  logic [REG_W-1:0] i_rs2,
    output logic [TAG_W-1:0] o_qj,
    output logic [TAG_W-1:0] o_qk,
    input  logic             i_wr_en,
    input  logic [REG_W-1:0] i_wr_idx,
    input  logic [TAG_W-1:0] i_wr_tag,
    input  logic             i_cdb_valid,
    input  logic [TAG_W-1:0] i_cdb_tag
);

    logic [TAG_W-1:0] r_qi [NUM_REGS];
    logic             w_cdb_ativo;

    // Tag 0 means "value ready", so a broadcast of tag 0 carries no information.
    assign w_cdb_ativo = i_cdb_valid && (i_cdb_tag != '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_qi[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (i_wr_en && (i_wr_idx == REG_W'(i))) begin
                    r_qi[i] <= i_wr_tag;
                end else if (w_cdb_ativo && (r_qi[i] == i_cdb_tag)) begin
                    r_qi[i] <= '0;
                end
            end
        end
    end

    always_comb begin
        o_qj = r_qi[i_rs1];
        o_qk = r_qi[i_rs2];
        if (w_cdb_ativo && (r_qi[i_rs1] == i_cdb_tag)) o_qj = '0;
        if (w_cdb_ativo && (r_qi[i_rs2] == i_cdb_tag)) o_qk = '0;
    end

endmodule

// File: rtl/unidade_de_despacho.sv
// Dispatch unit: pops the instruction queue, decodes, issues to reservation stations.
// Optional counters enabled by defining DESPACHO_CONTADOR_EN.
module unidade_de_despacho
    import despacho_pkg::*;
(
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Empty,
    input  logic [15:0]      Instrucao_Despachada,
    output logic             Pop,
    input  logic             CDB_Valid,
    input  logic [TAG_W-1:0] CDB_Tag,
    output logic             Issue_Valid,
    input  logic             Issue_Ack,
    input  logic [TAG_W-1:0] Ack_Tag,
    output logic [1:0]       Unit_Sel,
    output logic [3:0]       Issue_Op,
    output logic [3:0]       Issue_Rd,
    output logic [TAG_W-1:0] Issue_Qj,
    output logic [TAG_W-1:0] Issue_Qk,
    output logic [3:0]       Issue_Rs1,
    output logic [3:0]       Issue_Rs2,
`ifdef DESPACHO_CONTADOR_EN
    output logic [15:0]      Issued_Count,
    output logic [7:0]       Dropped_Count,
`endif
    output logic             Illegal
);

    estado_t     r_estado;
    estado_t     w_prox_estado;
    logic [15:0] r_ir;
    logic        r_pop;
    logic        r_illegal;
    logic [3:0]  w_op_in;
    logic        w_captura;
    logic        w_ack;
    logic        w_drop;

    assign w_op_in   = Instrucao_Despachada[15:12];
    assign w_captura = (r_estado == S_POP);
    assign w_ack     = (r_estado == S_ISSUE) && Issue_Ack;
    assign w_drop    = w_captura && !op_valido(w_op_in);

    always_comb begin
        w_prox_estado = r_estado;
        case (r_estado)
            S_IDLE:  if (!Empty) w_prox_estado = S_POP;
            S_POP:   w_prox_estado = op_valido(w_op_in) ? S_ISSUE : S_IDLE;
            S_ISSUE: if (Issue_Ack) w_prox_estado = Empty ? S_IDLE : S_POP;
            default: w_prox_estado = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_estado  <= S_IDLE;
            r_ir      <= '0;
            r_pop     <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_estado  <= w_prox_estado;
            r_pop     <= (w_prox_estado == S_POP);
            r_illegal <= w_drop && (w_op_in != OP_NOP);
            if (w_captura) r_ir <= Instrucao_Despachada;
        end
    end

    assign Pop         = r_pop;
    assign Illegal     = r_illegal;
    assign Issue_Valid = (r_estado == S_ISSUE);
    assign Issue_Op    = r_ir[15:12];
    assign Issue_Rd    = r_ir[11:8];
    assign Issue_Rs1   = r_ir[7:4];
    assign Issue_Rs2   = r_ir[3:0];
    assign Unit_Sel    = unidade_de(r_ir[15:12]);

    tabela_status_registradores u_tabela (
        .i_clk       (Clock),
        .i_rst_n     (Reset),
        .i_rs1       (r_ir[7:4]),
        .i_rs2       (r_ir[3:0]),
        .o_qj        (Issue_Qj),
        .o_qk        (Issue_Qk),
        .i_wr_en     (w_ack && escreve_rd(r_ir[15:12])),
        .i_wr_idx    (r_ir[11:8]),
        .i_wr_tag    (Ack_Tag),
        .i_cdb_valid (CDB_Valid),
        .i_cdb_tag   (CDB_Tag)
    );

`ifdef DESPACHO_CONTADOR_EN
    logic [15:0] r_issued_count;
    logic [7:0]  r_dropped_count;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_issued_count  <= '0;
            r_dropped_count <= '0;
        end else begin
            if (w_ack) r_issued_count <= r_issued_count + 16'd1;
            if (w_drop && (r_dropped_count != 8'hFF)) begin
                r_dropped_count <= r_dropped_count + 8'd1;
            end
        end
    end

    assign Issued_Count  = r_issued_count;
    assign Dropped_Count = r_dropped_count;
`endif

endmodule

// File: doc/unidade_de_despacho.md
UNIDADE_DE_DESPACHO -- requirements
Module: unidade_de_despacho

Interface
REQ-001 SHALL have port Clock, input, 1, single clock; all state changes on posedge.
REQ-002 SHALL have port Reset, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port Empty, input, 1, instruction-queue empty flag.
REQ-004 SHALL have port Instrucao_Despachada, input, 16, instruction presented by the queue.
REQ-005 SHALL have port Pop, output, 1, registered queue dispatch request.
REQ-006 SHALL have ports CDB_Valid (input, 1) and CDB_Tag (input, 4), result broadcast from the common data bus.
REQ-007 SHALL have ports Issue_Valid (output, 1), Issue_Ack (input, 1) and Ack_Tag (input, 4), the reservation-station issue handshake; Ack_Tag is the nonzero tag of the allocated entry.
REQ-008 SHALL have issue payload outputs Unit_Sel (2), Issue_Op (4), Issue_Rd (4), Issue_Qj (4), Issue_Qk (4), Issue_Rs1 (4) and Issue_Rs2 (4).
REQ-009 SHALL have port Illegal, output, 1, one-cycle pulse on an undefined opcode.

Function
REQ-010 SHALL split each instruction as opcode [15:12], rd [11:8], rs1 [7:4], rs2 [3:0].
REQ-011 SHALL decode opcodes: 0000 NOP, 0001 LD, 0010 ST, 0011 ADD, 0100 SUB, 0101 MUL.
REQ-012 SHALL route by Unit_Sel: ADD/SUB -> 00 (ALU), MUL -> 01, LD/ST -> 10 (MEM).
REQ-013 SHALL implement a finite-state machine with states S_IDLE, S_POP and S_ISSUE.
REQ-014 SHALL, in S_IDLE, move to S_POP when Empty is 0.
REQ-015 SHALL hold Pop at 1 for exactly the one cycle spent in S_POP.
REQ-016 SHALL, at the posedge leaving S_POP, capture Instrucao_Despachada into the IR; the queue updates on the intervening negedge.
REQ-017 SHALL, after capture, go to S_ISSUE for opcodes 0001-0101.
REQ-018 SHALL, after capture, drop the instruction and return to S_IDLE for NOP (16'h0000, the queue's empty-slot value).
REQ-019 SHALL, for opcodes 0110-1111, drop the instruction, pulse Illegal for one cycle and return to S_IDLE.
REQ-020 SHALL, in S_ISSUE, hold Issue_Valid at 1 with a stable payload until a posedge samples Issue_Ack at 1.
REQ-021 SHALL, on the ack posedge, go to S_POP if Empty is 0, else to S_IDLE; best-case throughput is 1 instruction per 2 cycles.
REQ-022 SHALL keep a 16-entry register status table (Qi, 4 bits per entry), where Qi = 0 means the value is in the register file.
REQ-023 SHALL drive Issue_Qj = Qi[rs1] and Issue_Qk = Qi[rs2], forced to 0 when CDB_Valid is 1 and CDB_Tag equals that entry, as a same-cycle bypass.
REQ-024 SHALL, on the ack posedge, write Qi[rd] <= Ack_Tag for LD/ADD/SUB/MUL; ST writes no Qi entry.
REQ-025 SHALL, on every posedge with CDB_Valid at 1, clear all entries whose value equals CDB_Tag.
REQ-026 SHALL give a same-posedge issue write to rd priority over the CDB clear of rd.
REQ-027 SHALL ignore CDB_Valid when CDB_Tag is 0.

Reset
REQ-028 SHALL, while Reset is 0, force state S_IDLE with Pop, Issue_Valid and Illegal at 0, the IR at 0, the payload outputs at 0 and all Qi at 0.
REQ-029 SHALL, on reset mid-operation, discard the captured or pending instruction without issue; no Pop pulse is produced on the release edge.

Configuration
REQ-030 SHALL, with DESPACHO_CONTADOR_EN defined, add output Issued_Count (16 bits), reset 0, incremented on each acked issue and wrapping FFFF -> 0000, plus output Dropped_Count (8 bits), incremented on each NOP or illegal drop and saturating at FF.
REQ-031 SHALL, without DESPACHO_CONTADOR_EN, have neither port nor the counter logic.

Structure
REQ-032 SHALL put the opcode constants, Unit_Sel codes, state encoding and tag width (4) in the shared package despacho_pkg.
REQ-033 SHALL implement the register status table as the sub-module tabela_status_registradores, with 2 combinational read ports, 1 issue write port, a CDB clear and async reset.

Verification
REQ-034 SHALL cover: Empty=0, queue holds 16'h3123 (ADD r1,r2,r3), Ack on the first S_ISSUE cycle with Ack_Tag=5 -> one Pop pulse, Unit_Sel=00, Qj=Qk=0, then Qi[1]=5.
REQ-035 SHALL cover: next instruction 16'h5414 (MUL r4,r1,r4) while Qi[1]=5 and no CDB -> Issue_Qj=5 and Issue_Qk=0; then CDB_Valid=1 with CDB_Tag=5 in the same cycle -> Issue_Qj=0.
REQ-036 SHALL cover: Issue_Ack held 0 for 4 cycles -> Issue_Valid stays 1, payload stable, no further Pop, Qi unchanged.
REQ-037 SHALL cover: 16'h0000 then 16'hA000 -> no Issue_Valid, Illegal pulses once for 16'hA000, FSM returns to S_IDLE; with DESPACHO_CONTADOR_EN, Dropped_Count=2.
REQ-038 SHALL cover: ack writing Qi[2]=7 on the same posedge as CDB_Tag=7 -> Qi[2]=7 retained.
REQ-039 SHALL cover: Reset pulsed low during S_ISSUE -> Issue_Valid=0 and all Qi=0 immediately, and the first Pop comes no earlier than 1 cycle after release.
